// File: rtl/islip_scheduler.sv
// iSLIP grant/accept matching scheduler for an N x N crossbar with persistent round-robin pointers.
// Optional macro ISLIP_EARLY_EXIT_EN ends a round once every input is matched or an iteration adds no match.
`timescale 1ns/1ps

module islip_rr_pick #(
    parameter int N    = 16,
    parameter int LOGN = 4
) (
    input  logic [N-1:0]    i_vec,
    input  logic [LOGN-1:0] i_ptr,
    output logic            o_found,
    output logic [LOGN-1:0] o_idx
);
    logic [LOGN:0] w_pos;

    // Scan from the far end so the candidate closest to i_ptr is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = {1'b0, i_ptr} + (LOGN+1)'(k);
            if (w_pos >= (LOGN+1)'(N)) w_pos = w_pos - (LOGN+1)'(N);
            if (i_vec[w_pos[LOGN-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_pos[LOGN-1:0];
            end
        end
    end
endmodule

module islip_scheduler #(
    parameter int N    = 16,
    parameter int LOGN = 4,
    parameter int ITER = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*N-1:0]    req,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      in_vld,
    output logic [N*LOGN-1:0] in_sel,
    output logic [N-1:0]      out_vld,
    output logic [N*LOGN-1:0] out_sel
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACCEPT, S_DONE} state_t;
    state_t r_state, w_next;

    logic [CW-1:0]              r_cnt;
    logic [N-1:0][N-1:0]        r_req;       // [input][output]
    logic [N-1:0]               r_in_vld, r_out_vld, r_gnt_vld;
    logic [N-1:0][LOGN-1:0]     r_in_sel, r_out_sel, r_gptr, r_aptr, r_gnt_idx;
    logic                       r_busy, r_done;

    logic [N-1:0][N-1:0]        w_elig;      // [output][input]
    logic [N-1:0][N-1:0]        w_gnt_vec;   // [input][output]
    logic [N-1:0]               w_gnt_found, w_acc_vld, w_out_acc;
    logic [N-1:0][LOGN-1:0]     w_gnt_pick, w_acc_idx;
    logic                       w_first;

    assign w_first = (r_cnt == '0);

    // Lane gl acts as output gl for the grant picker and as input gl for the accept picker.
    genvar gl, gk;
    generate
        for (gl = 0; gl < N; gl++) begin : g_lane
            for (gk = 0; gk < N; gk++) begin : g_x
                assign w_elig[gl][gk]    = r_req[gk][gl] & ~r_in_vld[gk] & ~r_out_vld[gl];
                assign w_gnt_vec[gl][gk] = r_gnt_vld[gk] & ~r_in_vld[gl] & (r_gnt_idx[gk] == LOGN'(gl));
            end
            islip_rr_pick #(.N(N), .LOGN(LOGN)) u_gnt (
                .i_vec(w_elig[gl]), .i_ptr(r_gptr[gl]),
                .o_found(w_gnt_found[gl]), .o_idx(w_gnt_pick[gl])
            );
            islip_rr_pick #(.N(N), .LOGN(LOGN)) u_acc (
                .i_vec(w_gnt_vec[gl]), .i_ptr(r_aptr[gl]),
                .o_found(w_acc_vld[gl]), .o_idx(w_acc_idx[gl])
            );
            assign w_out_acc[gl] = r_gnt_vld[gl] & w_acc_vld[r_gnt_idx[gl]]
                                 & (w_acc_idx[r_gnt_idx[gl]] == LOGN'(gl));
        end
    endgenerate

`ifdef ISLIP_EARLY_EXIT_EN
    logic w_all_matched, w_no_accept;
    assign w_all_matched = &(r_in_vld | w_acc_vld);
    assign w_no_accept   = ~|w_acc_vld;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_GRANT;
            S_GRANT:  w_next = S_ACCEPT;
            S_ACCEPT: begin
                w_next = (r_cnt == LAST) ? S_DONE : S_GRANT;
`ifdef ISLIP_EARLY_EXIT_EN
                if (w_all_matched || w_no_accept) w_next = S_DONE;
`endif
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_req     <= '0;
            r_in_vld  <= '0;
            r_out_vld <= '0;
            r_in_sel  <= '0;
            r_out_sel <= '0;
            r_gnt_vld <= '0;
            r_gnt_idx <= '0;
            r_gptr    <= '0;
            r_aptr    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_req     <= req;
                        r_in_vld  <= '0;
                        r_out_vld <= '0;
                        r_in_sel  <= '0;
                        r_out_sel <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                    end else if (r_done) begin
                        r_busy <= 1'b0;
                    end
                end
                S_GRANT: begin
                    r_gnt_vld <= w_gnt_found;
                    r_gnt_idx <= w_gnt_pick;
                end
                S_ACCEPT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // Pointers only move for first-iteration matches to keep iSLIP's fairness.
                    for (int i = 0; i < N; i++) begin
                        if (w_acc_vld[i]) begin
                            r_in_vld[i] <= 1'b1;
                            r_in_sel[i] <= w_acc_idx[i];
                            if (w_first)
                                r_aptr[i] <= (w_acc_idx[i] == LOGN'(N-1)) ? '0 : w_acc_idx[i] + LOGN'(1);
                        end
                        if (w_out_acc[i]) begin
                            r_out_vld[i] <= 1'b1;
                            r_out_sel[i] <= r_gnt_idx[i];
                            if (w_first)
                                r_gptr[i] <= (r_gnt_idx[i] == LOGN'(N-1)) ? '0 : r_gnt_idx[i] + LOGN'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign in_vld  = r_in_vld;
    assign in_sel  = r_in_sel;
    assign out_vld = r_out_vld;
    assign out_sel = r_out_sel;
endmodule

// File: tb/tb_islip_scheduler.sv
// Scoreboard bench for islip_scheduler: a queue-based iSLIP reference model predicts each round's matching and done cycle.
`timescale 1ns/1ps

module tb_islip_scheduler;
    localparam int N = 16, LOGN = 4, ITER = 2;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [N*N-1:0] req = '0;
    logic busy, done;
    logic [N-1:0] in_vld, out_vld;
    logic [N*LOGN-1:0] in_sel, out_sel;

    islip_scheduler #(.N(N), .LOGN(LOGN), .ITER(ITER)) dut (
        .clk(clk), .rst(rst), .start(start), .req(req),
        .busy(busy), .done(done),
        .in_vld(in_vld), .in_sel(in_sel), .out_vld(out_vld), .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0]      iv;
        logic [N*LOGN-1:0] is;
        logic [N-1:0]      ov;
        logic [N*LOGN-1:0] os;
        int                dcyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    exp_t mon_e;
    int   gp[N], ap[N];
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: iterate grant/accept over plain integer match tables.
    task automatic model_round(input logic [N*N-1:0] r, output exp_t e, output int iters);
        int in_m[N], out_m[N], gnt[N], acc[N];
        int i, j, nacc, nmatch;
        for (int k = 0; k < N; k++) begin in_m[k] = -1; out_m[k] = -1; end
        iters = 0;
        for (int it = 0; it < ITER; it++) begin
            iters = it + 1;
            for (int jj = 0; jj < N; jj++) begin
                gnt[jj] = -1;
                if (out_m[jj] < 0)
                    for (int k = 0; k < N; k++) begin
                        i = (gp[jj] + k) % N;
                        if (r[i*N+jj] && in_m[i] < 0) begin gnt[jj] = i; break; end
                    end
            end
            for (int ii = 0; ii < N; ii++) begin
                acc[ii] = -1;
                if (in_m[ii] < 0)
                    for (int k = 0; k < N; k++) begin
                        j = (ap[ii] + k) % N;
                        if (gnt[j] == ii) begin acc[ii] = j; break; end
                    end
            end
            nacc = 0;
            for (int ii = 0; ii < N; ii++) begin
                if (acc[ii] >= 0) begin
                    j = acc[ii];
                    in_m[ii] = j;
                    out_m[j] = ii;
                    nacc++;
                    if (it == 0) begin gp[j] = (ii + 1) % N; ap[ii] = (j + 1) % N; end
                end
            end
            nmatch = 0;
            for (int k = 0; k < N; k++) if (in_m[k] >= 0) nmatch++;
`ifdef ISLIP_EARLY_EXIT_EN
            if (nacc == 0 || nmatch == N) break;
`endif
        end
        e.iv = '0; e.is = '0; e.ov = '0; e.os = '0; e.dcyc = 0;
        for (int k = 0; k < N; k++) begin
            if (in_m[k] >= 0)  begin e.iv[k] = 1'b1; e.is[k*LOGN +: LOGN] = LOGN'(in_m[k]); end
            if (out_m[k] >= 0) begin e.ov[k] = 1'b1; e.os[k*LOGN +: LOGN] = LOGN'(out_m[k]); end
        end
    endtask

    task automatic issue(input logic [N*N-1:0] r, input bit expect_done);
        exp_t e;
        int iters;
        @(negedge clk);
        req = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_rise", busy, 1'b1);
        model_round(r, e, iters);
        e.dcyc = cyc + 2*iters + 1;
        if (expect_done) begin
            exp_q.push_back(e);
            last_e = e;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_q.size() > 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL done_timeout: %0d rounds pending after %0d cycles", exp_q.size(), t);
            exp_q.delete();
        end
    endtask

    task automatic check_hold();
        @(negedge clk);
        chk("hold_in_vld", in_vld, last_e.iv);
        chk("hold_out_sel", out_sel, last_e.os);
    endtask

    // Monitor: every done pulse must match the oldest predicted round.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: cycle %0d with no round pending", cyc);
            end else begin
                bit ok;
                int j;
                mon_e = exp_q.pop_front();
                chk("done_cycle", cyc, mon_e.dcyc);
                chk("busy_at_done", busy, 1'b1);
                chk("in_vld", in_vld, mon_e.iv);
                chk("in_sel", in_sel, mon_e.is);
                chk("out_vld", out_vld, mon_e.ov);
                chk("out_sel", out_sel, mon_e.os);
                ok = ($countones(in_vld) == $countones(out_vld));
                for (int i = 0; i < N; i++)
                    if (in_vld[i]) begin
                        j = int'(in_sel[i*LOGN +: LOGN]);
                        if (!out_vld[j] || out_sel[j*LOGN +: LOGN] != LOGN'(i)) ok = 1'b0;
                    end
                chk("match_consistent", ok, 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*N-1:0] all1, diag, wrap, r1;
        int p;
        all1 = '1;
        diag = '0;
        for (int i = 0; i < N; i++) diag[i*N+i] = 1'b1;
        wrap = '0;
        wrap[15*N+15] = 1'b1;
        wrap[0*N+15]  = 1'b1;
        for (int k = 0; k < N; k++) begin gp[k] = 0; ap[k] = 0; end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_in_vld", in_vld, '0);
        chk("rst_out_vld", out_vld, '0);
        chk("rst_in_sel", in_sel, '0);
        chk("rst_out_sel", out_sel, '0);

        issue('0, 1'b1); wait_done(); check_hold();

        issue(all1, 1'b1); wait_done();
        chk("fair1_in_vld", in_vld, 64'h3);
        chk("fair1_in_sel", in_sel, 64'h10);
        issue(all1, 1'b1); wait_done();
        chk("fair2_in_vld", in_vld, 64'h7);
        chk("fair2_in_sel", in_sel, 64'h201);
        chk("fair2_out_sel", out_sel, 64'h201);

        issue(diag, 1'b1); wait_done();
        chk("diag_in_vld", in_vld, 64'hFFFF);
        chk("diag_in_sel", in_sel, 64'hFEDCBA9876543210);

        issue(wrap, 1'b1); wait_done();
        chk("wrap1_out_vld", out_vld, 64'h8000);
        chk("wrap1_src", out_sel[63:60], 4'h0);
        issue(wrap, 1'b1); wait_done();
        chk("wrap2_src", out_sel[63:60], 4'hF);

        r1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        issue(r1, 1'b1);
        @(negedge clk);
        req = ~r1;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);

        issue(all1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin gp[k] = 0; ap[k] = 0; end
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_vld", in_vld, '0);
        chk("mid_rst_out_sel", out_sel, '0);
        repeat (8) @(negedge clk);
        issue(all1, 1'b1); wait_done();
        chk("after_rst_in_vld", in_vld, 64'h3);
        chk("after_rst_out_sel", out_sel, 64'h10);

        for (int n = 0; n < 40; n++) begin
            p = $urandom_range(0, 100);
            for (int b = 0; b < N*N; b++) r1[b] = ($urandom_range(0, 99) < p);
            issue(r1, 1'b1);
            wait_done();
            if ($urandom_range(0, 1) == 1) check_hold();
        end

        repeat (6) @(negedge clk);
        chk("pending_rounds", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/islip_scheduler.md
Name: islip_scheduler

Overview:
- Iterative round-robin (iSLIP) matching scheduler for the 16x16 crossbar datapath.
- Per cycle-slot it takes the per-input virtual-output-queue occupancy matrix and computes a conflict-free input-to-output matching.
- It drives each input queue's dequeue select and each output's source select.
- It sits between the input queues (request source) and the crossbar output muxes (select consumers), and replaces the independent per-output arbiters.

Parameters:
- N, 16, number of crossbar inputs and outputs.
- LOGN, 4, index width; must equal clog2(N).
- ITER, 2, maximum grant/accept iterations per scheduling round (1..N).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a scheduling round; sampled only in IDLE.
- req  input  N*N  request matrix; req[i*N+j]=1 means input i has a cell for output j. Latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done inclusive.
- done  output  1  one-cycle pulse: matching valid and stable.
- in_vld  output  N  in_vld[i]=1 means input i is matched.
- in_sel  output  N*LOGN  in_sel[i*LOGN+:LOGN] is the output index assigned to input i.
- out_vld  output  N  out_vld[j]=1 means output j is matched.
- out_sel  output  N*LOGN  out_sel[j*LOGN+:LOGN] is the input index driving output j.

Behaviour:
- Reset: busy=0, done=0, in_vld=0, out_vld=0, in_sel=0, out_sel=0. All grant pointers g_ptr[j]=0, all accept pointers a_ptr[i]=0. FSM goes to IDLE.
- FSM states: IDLE, GRANT, ACCEPT, DONE.
  - IDLE, start=1: latch req, clear in_vld/out_vld/in_sel/out_sel, set iteration count=0, go to GRANT.
  - GRANT -> ACCEPT, always.
  - ACCEPT -> GRANT if count+1<ITER, otherwise -> DONE.
  - DONE: done=1 for one cycle, -> IDLE.
- start is ignored in GRANT, ACCEPT and DONE; it is not queued.
- GRANT step: each unmatched output j considers requests from unmatched inputs only. It grants the first requesting input at or after g_ptr[j], searching cyclically modulo N. An output with no eligible request issues no grant.
- ACCEPT step: each unmatched input i accepts the first granting output at or after a_ptr[i], searching cyclically modulo N. Accepted pairs set in_vld/in_sel and out_vld/out_sel at the ACCEPT clock edge.
- Pointer update happens only for pairs accepted in the first iteration (count==0):
  - g_ptr[j] <= (i+1) mod N.
  - a_ptr[i] <= (j+1) mod N.
  - Wrap-around: index N-1 advances to 0.
  - Pairs accepted in later iterations never move pointers.
- Pointers persist across rounds and are cleared only by rst.
- Latency: done is asserted exactly 2*ITER+1 cycles after the start-sampling edge (5 for ITER=2). busy falls with done.
- Match outputs hold their values after done until the next accepted start.
- Empty req (all zero): the full iteration count still runs, done pulses, and all vld=0.
- Matching invariant: at most one 1 per row and per column; in_sel/out_sel are mutually consistent.
- rst mid-round: the round is aborted immediately and all state returns to reset values; no done pulse.

Optional Feature:
- Macro: ISLIP_EARLY_EXIT_EN.
- Defined: in ACCEPT, go to DONE early if every input is matched, or if the current iteration produced zero new accepts, even when count+1<ITER. done latency becomes 2*k+1 cycles, where k is the number of iterations executed.
- Undefined: always run ITER iterations; latency is fixed at 2*ITER+1.

Test Plan:
- Reset check: after rst, busy/done/in_vld/out_vld all 0, all selects 0. Then req=0 with start -> done 5 cycles later, in_vld=0, out_vld=0.
- Diagonal req (req[i*N+i]=1 for all i), start -> all 16 matched with in_sel[i]=i, out_sel[i]=i, done at +5 (+3 with ISLIP_EARLY_EXIT_EN and ITER=2; +3 with early exit and ITER=4).
- Fairness, all-ones req from reset, ITER=2:
  - Round 1 matches (0,0),(1,1) only.
  - Round 2 (all-ones again) matches (0,1),(1,0),(2,2).
  - Pointers: after round 1 g_ptr[0]=1, a_ptr[0]=1; after round 2 g_ptr[1]=1, a_ptr[0]=2, g_ptr[0]=2, a_ptr[1]=1.
- Wrap-around: req has only input 15 -> output 15 and input 0 -> output 15. First round matches (15,15) if g_ptr[15] was set to 15, otherwise (0,15); g_ptr[15] then becomes 0 or 1 respectively, and the next round grants the other input.
- Busy protection: pulse start again 2 cycles into a round with a different req -> result reflects the first req only, one done pulse.
- Reset mid-round: assert rst in the ACCEPT cycle of iteration 1 -> no done pulse, all outputs 0, pointers 0. The next all-ones round reproduces the round-1 result (0,0),(1,1).
